// File: rtl/gp_reg_file_pkg.sv
// rtl/gp_reg_file_pkg.sv - shared defaults, register index helpers and cell kinds for gp_reg_file
// Used by gp_reg_file and gp_reg_cell; stack pointer placement depends on REGFILE_SP_EN at the top.
package gp_reg_file_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_NREGS    = 8;
  localparam int DEFAULT_PC_RESET = 0;
  localparam int MIN_NREGS        = 3;
  localparam int MAX_NREGS        = 16;

  localparam int DEFAULT_PC_IDX = DEFAULT_NREGS - 1;
  localparam int DEFAULT_SP_IDX = DEFAULT_NREGS - 2;

  typedef enum logic [1:0] {
    CELL_GP = 2'd0,
    CELL_PC = 2'd1,
    CELL_SP = 2'd2
  } cellKind_e;

  function automatic int pcIndex(input int nregs);
    return nregs - 1;
  endfunction

  function automatic int spIndex(input int nregs);
    return nregs - 2;
  endfunction

  function automatic cellKind_e cellKindOf(input int idx, input int nregs, input bit spEn);
    if (idx == pcIndex(nregs)) begin
      return CELL_PC;
    end
    if (spEn && idx == spIndex(nregs)) begin
      return CELL_SP;
    end
    return CELL_GP;
  endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// rtl/gp_reg_cell.sv - one register with load, +1/-1 step and two tri-state read drivers
// Load beats step; inc and dec together hold. Drive selects are already priority-resolved by the parent.
module gp_reg_cell
  import gp_reg_file_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  input  logic             driveA,
  input  logic             driveB,
  inout  wire  [WIDTH-1:0] aBus,
  inout  wire  [WIDTH-1:0] bBus
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock) begin
    if (!notReset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else if (inc ^ dec) begin
      q <= inc ? q + 1'b1 : q - 1'b1;
    end
  end

  // Drivers read the stored value only, so a same-cycle load is not visible until after the edge.
  assign aBus = driveA ? q : {WIDTH{1'bz}};
  assign bBus = driveB ? q : {WIDTH{1'bz}};

endmodule

// File: rtl/gp_reg_file.sv
// rtl/gp_reg_file.sv - register file with PC, two tri-state read buses and conflict flag
// Optional stack pointer at index NREGS-2 when REGFILE_SP_EN is defined.
module gp_reg_file
  import gp_reg_file_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               NREGS    = DEFAULT_NREGS,
  parameter logic [WIDTH-1:0] PC_RESET = WIDTH'(DEFAULT_PC_RESET)
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic [NREGS-1:0] notLoad,
  input  logic [NREGS-1:0] notOE,
  input  logic [NREGS-1:0] notOEB,
  input  logic             pcInc,
`ifdef REGFILE_SP_EN
  input  logic             spInc,
  input  logic             spDec,
`endif
  inout  wire  [WIDTH-1:0] yBus,
  inout  wire  [WIDTH-1:0] aBus,
  inout  wire  [WIDTH-1:0] bBus,
  output logic             busConflict
);

`ifdef REGFILE_SP_EN
  localparam bit SP_EN = 1'b1;
`else
  localparam bit SP_EN = 1'b0;
`endif

  logic [NREGS-1:0] enA;
  logic [NREGS-1:0] enB;
  logic [NREGS-1:0] selA;
  logic [NREGS-1:0] selB;
  logic             conflictA;
  logic             conflictB;

  assign enA = ~notOE;
  assign enB = ~notOEB;

  // x & -x isolates the lowest set bit, so at most one cell ever drives each bus.
  assign selA = enA & (~enA + NREGS'(1));
  assign selB = enB & (~enB + NREGS'(1));

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign conflictA = |(enA & (enA - NREGS'(1)));
  assign conflictB = |(enB & (enB - NREGS'(1)));

  always_ff @(posedge clock) begin
    if (!notReset) begin
      busConflict <= 1'b0;
    end else begin
      busConflict <= conflictA | conflictB;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : gCell
    localparam cellKind_e KIND = cellKindOf(i, NREGS, SP_EN);

    logic cellInc;
    logic cellDec;

    if (KIND == CELL_PC) begin : gPc
      assign cellInc = pcInc;
      assign cellDec = 1'b0;
    end else if (KIND == CELL_SP) begin : gSp
`ifdef REGFILE_SP_EN
      assign cellInc = spInc;
      assign cellDec = spDec;
`else
      assign cellInc = 1'b0;
      assign cellDec = 1'b0;
`endif
    end else begin : gGp
      assign cellInc = 1'b0;
      assign cellDec = 1'b0;
    end

    gp_reg_cell #(
      .WIDTH    (WIDTH),
      .RESET_VAL((KIND == CELL_PC) ? PC_RESET : {WIDTH{1'b0}})
    ) uCell (
      .clock   (clock),
      .notReset(notReset),
      .load    (~notLoad[i]),
      .inc     (cellInc),
      .dec     (cellDec),
      .d       (yBus),
      .driveA  (selA[i]),
      .driveB  (selB[i]),
      .aBus    (aBus),
      .bBus    (bBus)
    );
  end

endmodule

// File: doc/gp_reg_file.md
GP_REG_FILE -- requirements
Module: gp_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every register and bus.
REQ-002 SHALL have parameter NREGS, default 8, total registers including PC; PC is index NREGS-1; legal range 3..16.
REQ-003 SHALL have parameter PC_RESET, default 0, PC value loaded at reset.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port notReset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port notLoad  input  NREGS  active-low per-register load enable from yBus.
REQ-007 SHALL have port notOE  input  NREGS  active-low per-register drive enable onto aBus.
REQ-008 SHALL have port notOEB  input  NREGS  active-low per-register drive enable onto bBus (second read port).
REQ-009 SHALL have port pcInc  input  1  PC increment request.
REQ-010 SHALL have port yBus  inout  WIDTH  write data bus; sampled only, never driven by this block.
REQ-011 SHALL have port aBus  inout  WIDTH  read bus A; high-Z when no notOE bit low.
REQ-012 SHALL have port bBus  inout  WIDTH  read bus B; high-Z when no notOEB bit low.
REQ-013 SHALL have port busConflict  output  1  registered flag: multiple enables low on one read bus in the previous cycle.

Function
REQ-014 Register i SHALL capture yBus on the rising edge when notLoad[i]=0, otherwise hold.
REQ-015 PC update priority SHALL be: reset > load (notLoad[NREGS-1]=0) > pcInc > hold.
REQ-016 PC increment SHALL be +1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-017 aBus SHALL be driven combinationally by the lowest-index register i with notOE[i]=0; bBus likewise with notOEB; zero latency.
REQ-018 The same register SHALL be readable on aBus and bBus in the same cycle.
REQ-019 A register loaded in a cycle SHALL present its old value on aBus/bBus until after the capturing edge (no write-through bypass).
REQ-020 Multiple notLoad bits low SHALL load all selected registers with the same yBus value.
REQ-021 busConflict SHALL be set at the next edge when two or more notOE bits, or two or more notOEB bits, are low; otherwise cleared at that edge.

Reset
REQ-022 With notReset=0 at a rising edge, GP registers SHALL clear to 0, PC SHALL load PC_RESET, SP (if present) SHALL clear to 0, busConflict SHALL clear to 0; reset overrides load, pcInc, spInc, spDec.
REQ-023 Bus drive SHALL stay combinational during reset; asserted enables drive current register contents.

Configuration
REQ-024 Macro REGFILE_SP_EN SHALL, when defined, turn register NREGS-2 into a stack pointer and add inputs spInc and spDec (1 bit each).
REQ-025 With REGFILE_SP_EN: SP priority SHALL be reset > load > (spInc xor spDec: +1 or -1 modulo 2^WIDTH) > hold; both asserted SHALL hold.
REQ-026 Without REGFILE_SP_EN, ports spInc/spDec SHALL not exist and register NREGS-2 SHALL behave as a plain GP register.

Structure
REQ-027 A shared package SHALL hold default WIDTH, NREGS, PC_RESET and the PC/SP index constants.
REQ-028 One sub-module, gp_reg_cell (one register with load, two tri-state drivers, optional inc/dec), SHALL be instantiated NREGS times, with PC and SP as configured instances.

Verification
REQ-029 Reset: notReset=0 one edge, PC_RESET=16'h0100 -> PC reads 16'h0100 on aBus, r0..r6 read 0, busConflict=0.
REQ-030 Load/read: yBus=16'hBEEF, notLoad[3]=0 one edge, then notOE[3]=0 and notOEB[3]=0 -> aBus=bBus=16'hBEEF; before the edge both show 0.
REQ-031 PC wrap: load PC 16'hFFFF, pcInc=1 one edge -> PC=16'h0000; pcInc with load of 16'h0010 same edge -> PC=16'h0010.
REQ-032 Conflict: notOE[1]=0 and notOE[2]=0 with r1=5, r2=9 -> aBus=5, busConflict=1 after next edge, 0 one edge after release.
REQ-033 SP (REGFILE_SP_EN): SP=0, spDec one edge -> 16'hFFFF; spInc and spDec together -> hold; spInc -> 16'h0000.
REQ-034 Reset mid-operation: notReset=0 with notLoad[0]=0 and pcInc=1 same edge -> r0=0, PC=PC_RESET.
